// File: rtl/tow_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tow_pkg
//  Description : Types and helpers shared by the tug-of-war match engine.
//                tow_state_e - match FSM states
//                tow_side_e  - player side (left / right)
//                tow_width() - minimum counter width for a value range
//  Revision    : 1.0 - initial release
// ============================================================================
package tow_pkg;

    typedef enum logic [1:0] {
        PLAY  = 2'd0,
        SCORE = 2'd1,
        OVER  = 2'd2
    } tow_state_e;

    typedef enum logic {
        SIDE_L = 1'b0,
        SIDE_R = 1'b1
    } tow_side_e;

    // Width needed to hold the values 0..n-1, never less than one bit.
    function automatic int tow_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/tow_hold_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tow_hold_timer
//  Description : Loadable down-counter used to hold the winning end LED after
//                a round win. Counts down to zero and stops there.
//  Ports       : clk     - system clock
//                reset   - synchronous active-high reset (count -> 0)
//                i_load  - load i_init (priority over counting)
//                i_en    - count enable (decrement while non-zero)
//                i_init  - load value
//                o_done  - count is zero
//  Revision    : 1.0 - initial release
// ============================================================================
module tow_hold_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic         i_en,
    input  logic [W-1:0] i_init,
    output logic         o_done
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_init;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_done = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/tow_match.sv
`default_nettype none
// ============================================================================
//  Module      : tow_match
//  Description : Two-player tug-of-war match engine. Tracks the rope position
//                on an N_LEDS bar, detects round wins, keeps per-player round
//                scores and declares the match winner at WIN_ROUNDS.
//  Ports       : clk          - system clock
//                reset        - synchronous active-high reset
//                pull_l       - left player pull pulse (edge-detected)
//                pull_r       - right player pull pulse (edge-detected)
//                pause        - freeze all state
//                leds         - one-hot rope position, MSB = leftmost
//                round_win_l  - one-cycle pulse, left won a round
//                round_win_r  - one-cycle pulse, right won a round
//                score_l      - left rounds won
//                score_r      - right rounds won
//                match_over   - match decided (level)
//                winner       - 0 = left, 1 = right (valid with match_over)
//  Revision    : 1.0 - initial release
// ============================================================================
module tow_match
    import tow_pkg::*;
#(
    parameter int N_LEDS      = 9,
    parameter int SCORE_W     = 3,
    parameter int WIN_ROUNDS  = 7,
    parameter int HOLD_CYCLES = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pull_l,
    input  logic               pull_r,
    input  logic               pause,
    output logic [N_LEDS-1:0]  leds,
    output logic               round_win_l,
    output logic               round_win_r,
    output logic [SCORE_W-1:0] score_l,
    output logic [SCORE_W-1:0] score_r,
    output logic               match_over,
    output logic               winner
);

    localparam int PW = tow_width(N_LEDS);
    localparam int HW = tow_width(HOLD_CYCLES);

    localparam logic [PW-1:0]      c_CENTER = PW'((N_LEDS - 1) / 2);
    localparam logic [PW-1:0]      c_LEFT   = PW'(N_LEDS - 1);
    localparam logic [PW-1:0]      c_RIGHT  = '0;
    localparam logic [HW-1:0]      c_HOLD   = HW'(HOLD_CYCLES - 1);
    localparam logic [SCORE_W-1:0] c_WIN    = SCORE_W'(WIN_ROUNDS);

    // ------------------------------------------------------------------
    // Parameter range checks
    // ------------------------------------------------------------------
    if ((N_LEDS < 3) || ((N_LEDS % 2) == 0)) begin : g_bad_n_leds
        $error("tow_match: N_LEDS must be odd and >= 3");
    end
    if ((WIN_ROUNDS < 1) || (WIN_ROUNDS > (2 ** SCORE_W) - 1)) begin : g_bad_win_rounds
        $error("tow_match: WIN_ROUNDS must be in 1..2**SCORE_W-1");
    end
    if (HOLD_CYCLES < 1) begin : g_bad_hold_cycles
        $error("tow_match: HOLD_CYCLES must be >= 1");
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    tow_state_e         r_state;
    tow_side_e          r_side;      // side that won the current round
    logic [PW-1:0]      r_pos;
    logic [N_LEDS-1:0]  r_leds;
    logic               r_rw_l;
    logic               r_rw_r;
    logic [SCORE_W-1:0] r_score_l;
    logic [SCORE_W-1:0] r_score_r;
    logic               r_over;
    logic               r_winner;

    tow_state_e         w_state_nxt;
    tow_side_e          w_side_nxt;
    logic [PW-1:0]      w_pos_nxt;
    logic               w_rw_l_nxt;
    logic               w_rw_r_nxt;
    logic [SCORE_W-1:0] w_score_l_nxt;
    logic [SCORE_W-1:0] w_score_r_nxt;
    logic               w_over_nxt;
    logic               w_winner_nxt;
    logic               w_hold_load;
    logic               w_hold_done;
    logic               w_mv_l;
    logic               w_mv_r;
    logic [SCORE_W-1:0] w_side_score;

    // Simultaneous pulls cancel out.
    assign w_mv_l = pull_l & ~pull_r;
    assign w_mv_r = pull_r & ~pull_l;

    assign w_side_score = (r_side == SIDE_L) ? r_score_l : r_score_r;

    // ------------------------------------------------------------------
    // Hold timer: loaded on the winning move, counts only in SCORE.
    // ------------------------------------------------------------------
    tow_hold_timer #(
        .W (HW)
    ) u_hold (
        .clk    (clk),
        .reset  (reset),
        .i_load (w_hold_load),
        .i_en   (~pause && (r_state == SCORE)),
        .i_init (c_HOLD),
        .o_done (w_hold_done)
    );

    // ------------------------------------------------------------------
    // Next-state / next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_side_nxt    = r_side;
        w_pos_nxt     = r_pos;
        w_rw_l_nxt    = 1'b0;
        w_rw_r_nxt    = 1'b0;
        w_score_l_nxt = r_score_l;
        w_score_r_nxt = r_score_r;
        w_over_nxt    = r_over;
        w_winner_nxt  = r_winner;
        w_hold_load   = 1'b0;

        if (!pause) begin
            case (r_state)
                PLAY: begin
                    if (w_mv_l) begin
                        if (r_pos == c_LEFT) begin
                            // Rope already at the left end: left takes the round.
                            w_state_nxt   = SCORE;
                            w_side_nxt    = SIDE_L;
                            w_rw_l_nxt    = 1'b1;
                            w_score_l_nxt = r_score_l + SCORE_W'(1);
                            w_hold_load   = 1'b1;
                        end else begin
                            w_pos_nxt = r_pos + PW'(1);
                        end
                    end else if (w_mv_r) begin
                        if (r_pos == c_RIGHT) begin
                            w_state_nxt   = SCORE;
                            w_side_nxt    = SIDE_R;
                            w_rw_r_nxt    = 1'b1;
                            w_score_r_nxt = r_score_r + SCORE_W'(1);
                            w_hold_load   = 1'b1;
                        end else begin
                            w_pos_nxt = r_pos - PW'(1);
                        end
                    end
                end
                SCORE: begin
                    if (w_hold_done) begin
                        if (w_side_score == c_WIN) begin
                            w_state_nxt  = OVER;
                            w_over_nxt   = 1'b1;
                            w_winner_nxt = (r_side == SIDE_R);
                        end else begin
                            w_state_nxt = PLAY;
                            w_pos_nxt   = c_CENTER;
                        end
                    end
                end
                OVER: begin
                    // Terminal until reset.
                end
                default: begin
                    w_state_nxt = PLAY;
                    w_pos_nxt   = c_CENTER;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= PLAY;
            r_side    <= SIDE_L;
            r_pos     <= c_CENTER;
            r_leds    <= N_LEDS'(1) << c_CENTER;
            r_rw_l    <= 1'b0;
            r_rw_r    <= 1'b0;
            r_score_l <= '0;
            r_score_r <= '0;
            r_over    <= 1'b0;
            r_winner  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_side    <= w_side_nxt;
            r_pos     <= w_pos_nxt;
            // Decode from the next position so leds are a pure register.
            r_leds    <= N_LEDS'(1) << w_pos_nxt;
            r_rw_l    <= w_rw_l_nxt;
            r_rw_r    <= w_rw_r_nxt;
            r_score_l <= w_score_l_nxt;
            r_score_r <= w_score_r_nxt;
            r_over    <= w_over_nxt;
            r_winner  <= w_winner_nxt;
        end
    end

    assign leds        = r_leds;
    assign round_win_l = r_rw_l;
    assign round_win_r = r_rw_r;
    assign score_l     = r_score_l;
    assign score_r     = r_score_r;
    assign match_over  = r_over;
    assign winner      = r_winner;

endmodule
`default_nettype wire
